lenet_layer_sched: RTL and testbench
====================================

Name: lenet_layer_sched

Overview:
- Network-level sequencer for the LeNet accelerator.
- Launches the layer stages (conv1, pool1, conv2, pool2, conv3) strictly in order.
- Each stage is launched a configurable number of times via a one-cycle enable, and the sequencer waits for that stage's finish pulse before the next launch.
- Provides per-stage watchdog timeout, abort, status and a whole-inference cycle count; sits above the layer tops and replaces their free-running enable ties.

Parameters:
- NUM_STAGES, 5, number of sequenced stages; stage 0 runs first.
- REP_W, 4, width of each per-stage repeat-count field.
- TIMEOUT, 200000, max cycles to wait for a finish pulse before error.
- CNT_W, 32, width of the total cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level/pulse; begins an inference when sampled high in IDLE, DONE or ERR.
- abort  in  1  synchronous abort; returns to IDLE.
- rep_cfg  in  NUM_STAGES*REP_W  launches per stage; field s = bits [s*REP_W +: REP_W]; captured at start; field value 0 is treated as 1.
- stage_en  out  NUM_STAGES  one-hot launch pulse, one cycle wide.
- stage_finish  in  NUM_STAGES  finish pulses from the stages.
- busy  out  1  high from the cycle after start until DONE, ERR or IDLE is reached.
- done  out  1  one-cycle pulse when the last launch of the last stage finishes.
- err  out  1  sticky timeout flag; cleared by start or abort.
- err_stage  out  3  stage index that timed out.
- cur_stage  out  3  index of the active stage.
- total_cycles  out  CNT_W  cycles from start accept to done, latched at done.

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs 0; internal counters 0; rep_cfg latch 0.
- States: IDLE, LAUNCH, WAIT, NEXT, DONE, ERR.
- IDLE/DONE/ERR, start=1 and abort=0:
  - latch rep_cfg; stage=0; rep=0; run counter=0; clear err and err_stage.
  - go to LAUNCH next cycle; busy=1 from that cycle.
- LAUNCH (1 cycle):
  - stage_en[stage]=1, registered; all other bits 0.
  - wait counter cleared; go to WAIT.
- WAIT: wait counter +1 per cycle; stage_finish sampled every cycle.
  - stage_finish[stage]=1 -> NEXT.
  - Finish bits of other stages are ignored.
  - Wait counter reaching TIMEOUT-1 with no finish -> ERR; err=1; err_stage=stage; busy=0.
  - Finish and timeout in the same cycle: finish wins.
- NEXT (1 cycle):
  - If rep+1 < effective rep_cfg[stage]: rep+1, go to LAUNCH (same stage).
  - Else if stage < NUM_STAGES-1: stage+1, rep=0, go to LAUNCH.
  - Else: go to DONE; done=1 for this single cycle; total_cycles latched; busy=0.
- DONE and ERR hold until start or abort. start in these states restarts exactly as from IDLE.
- abort: has priority over all events including start.
  - Any state -> IDLE on the next edge; stage_en forced 0 that cycle.
  - err cleared; total_cycles retained.
- start while busy (LAUNCH/WAIT/NEXT) is ignored.
- Run counter:
  - Increments every cycle while busy; saturates at all-ones.
  - total_cycles = number of cycles from the first LAUNCH cycle through the NEXT cycle that produces done, inclusive.
- cur_stage = stage register in every state; 0 in IDLE.
- Minimum stage launch spacing: LAUNCH, WAIT (≥1 cycle), NEXT = 3 cycles per launch.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: rst low while waiting on stage 2.
  - Response: stage_en=0, busy=0, cur_stage=0, done=0 immediately (async). No launch after rst rises until start.
- Nominal run:
  - Stimulus: rep_cfg=all 1; each stage model returns finish 5 cycles after its en.
  - Response: stage_en pulses bits 0,1,2,3,4 once each in order; done pulses once; total_cycles=5*(1+5+1)=35; busy low after done.
- Repeats:
  - Stimulus: rep_cfg field2=3, field0=0, others=1.
  - Response: stage_en[2] pulses 3 times, stage_en[0] once, each launch only after the prior finish; no other bits in between.
- Timeout:
  - Stimulus: TIMEOUT=16; stage 1 never finishes.
  - Response: err=1, err_stage=1 exactly 16 cycles after stage_en[1]; no stage_en[2]; a following start clears err and relaunches stage 0.
- Spurious and simultaneous events:
  - Stimulus: stage_finish[3] pulsed while waiting on stage 1.
  - Response: ignored; still waiting.
  - Stimulus: start asserted while busy.
  - Response: ignored.
  - Stimulus: finish on the timeout cycle.
  - Response: NEXT, no err.
- Abort:
  - Stimulus: abort and start high together during WAIT on stage 3.
  - Response: IDLE next cycle, busy=0, no stage_en; start accepted on the following cycle with abort low.

Source files
------------

// File: rtl/lenet_layer_sched.sv
// -----------------------------------------------------------------------------
// lenet_layer_sched
//
// Network-level sequencer for the LeNet accelerator. It launches the layer
// stages (conv1, pool1, conv2, pool2, conv3) strictly in order. Each stage is
// launched a configurable number of times with a one-cycle enable, and the
// sequencer waits for that stage's finish pulse before the next launch. It
// also provides a per-launch watchdog, abort, status and a whole-inference
// cycle count.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   start         begins an inference when sampled high in IDLE, DONE or ERR
//   abort         synchronous abort back to IDLE, beats every other event
//   rep_cfg       launches per stage, field s = [s*REP_W +: REP_W], 0 means 1
//   stage_en      one-hot launch pulse, one cycle wide
//   stage_finish  finish pulses returned by the stages
//   busy          high from the first LAUNCH cycle until DONE/ERR/IDLE
//   done          one-cycle pulse after the last launch of the last stage ends
//   err           sticky watchdog flag, cleared by start or abort
//   err_stage     index of the stage that timed out
//   cur_stage     index of the active stage (0 in IDLE)
//   total_cycles  cycles from the first LAUNCH through the final NEXT
// -----------------------------------------------------------------------------
module lenet_layer_sched #(
   parameter int NUM_STAGES = 5,
   parameter int REP_W      = 4,
   parameter int TIMEOUT    = 200000,
   parameter int CNT_W      = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [NUM_STAGES*REP_W-1:0] rep_cfg,
   output logic [NUM_STAGES-1:0]       stage_en,
   input  logic [NUM_STAGES-1:0]       stage_finish,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [2:0]                  err_stage,
   output logic [2:0]                  cur_stage,
   output logic [CNT_W-1:0]            total_cycles
);

   // Wide enough to hold TIMEOUT itself, so TIMEOUT-1 never truncates.
   localparam int WAIT_W = $clog2(TIMEOUT) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAUNCH = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_NEXT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERR    = 3'd5;

   localparam logic [NUM_STAGES-1:0] EN_ONE   = NUM_STAGES'(1);
   localparam logic [2:0]            LAST_STG = 3'(NUM_STAGES - 1);

   logic [2:0]                  r_state;
   logic [NUM_STAGES*REP_W-1:0] r_cfg;
   logic [2:0]                  r_stage;
   logic [REP_W-1:0]            r_rep;
   logic [WAIT_W-1:0]           r_wait;
   logic [CNT_W-1:0]            r_run;
   logic [NUM_STAGES-1:0]       r_stage_en;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_err;
   logic [2:0]                  r_err_stage;
   logic [CNT_W-1:0]            r_total;

   logic [REP_W-1:0]            w_fld;
   logic [REP_W:0]              w_eff_rep;
   logic [REP_W:0]              w_rep_inc;
   logic                        w_more_reps;
   logic                        w_last_stage;
   logic [NUM_STAGES-1:0]       w_en_cur;
   logic [NUM_STAGES-1:0]       w_en_nxt;
   logic                        w_fin;
   logic [WAIT_W-1:0]           w_wait_inc;
   logic                        w_timeout;
   logic                        w_idle_like;
   logic [CNT_W-1:0]            w_run_sat;

   // Repeat field of the active stage, taken from the copy latched at start.
   always_comb begin
      w_fld = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         if (r_stage == 3'(s)) begin
            w_fld = r_cfg[s*REP_W +: REP_W];
         end
      end
   end

   // A zero repeat field still runs the stage once.
   assign w_eff_rep    = (w_fld == '0) ? (REP_W+1)'(1) : {1'b0, w_fld};
   assign w_rep_inc    = {1'b0, r_rep} + (REP_W+1)'(1);
   assign w_more_reps  = (w_rep_inc < w_eff_rep);
   assign w_last_stage = (r_stage == LAST_STG);

   assign w_en_cur = EN_ONE << r_stage;
   assign w_en_nxt = EN_ONE << (r_stage + 3'd1);

   // Only the active stage's finish bit matters; others are ignored.
   assign w_fin = |(stage_finish & w_en_cur);

   // Watchdog fires on the WAIT cycle in which the incremented count reaches
   // TIMEOUT-1, so err shows up TIMEOUT cycles after the stage_en cycle and a
   // finish in that same cycle still wins.
   assign w_wait_inc = r_wait + WAIT_W'(1);
   assign w_timeout  = (w_wait_inc == WAIT_W'(TIMEOUT - 1));

   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) ||
                        (r_state == S_ERR);

   assign w_run_sat = (&r_run) ? r_run : (r_run + CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cfg       <= '0;
         r_stage     <= '0;
         r_rep       <= '0;
         r_wait      <= '0;
         r_run       <= '0;
         r_stage_en  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_stage <= '0;
         r_total     <= '0;
      end else begin
         // Launch enable and done are single-cycle pulses.
         r_stage_en <= '0;
         r_done     <= 1'b0;
         if (r_busy) begin
            r_run <= w_run_sat;
         end

         if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_stage <= '0;
            r_rep   <= '0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (start) begin
                     r_cfg       <= rep_cfg;
                     r_stage     <= '0;
                     r_rep       <= '0;
                     r_run       <= '0;
                     r_err       <= 1'b0;
                     r_err_stage <= '0;
                     r_busy      <= 1'b1;
                     r_stage_en  <= EN_ONE;
                     r_state     <= S_LAUNCH;
                  end
               end
               S_LAUNCH: begin
                  r_wait  <= '0;
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (w_fin) begin
                     r_state <= S_NEXT;
                  end else if (w_timeout) begin
                     r_state     <= S_ERR;
                     r_err       <= 1'b1;
                     r_err_stage <= r_stage;
                     r_busy      <= 1'b0;
                  end else begin
                     r_wait <= w_wait_inc;
                  end
               end
               S_NEXT: begin
                  if (w_more_reps) begin
                     r_rep      <= w_rep_inc[REP_W-1:0];
                     r_stage_en <= w_en_cur;
                     r_state    <= S_LAUNCH;
                  end else if (!w_last_stage) begin
                     r_stage    <= r_stage + 3'd1;
                     r_rep      <= '0;
                     r_stage_en <= w_en_nxt;
                     r_state    <= S_LAUNCH;
                  end else begin
                     // w_run_sat includes this NEXT cycle in the count.
                     r_total <= w_run_sat;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_DONE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign stage_en     = r_stage_en;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign err_stage    = r_err_stage;
   assign cur_stage    = r_stage;
   assign total_cycles = r_total;

endmodule

// File: tb/tb_lenet_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_lenet_layer_sched
//
// Bench for lenet_layer_sched (TIMEOUT reduced to 16). Stage models answer
// each launch with a finish pulse a programmable number of cycles later (or
// never). The expected launch order, launch cycles, done cycle and
// total_cycles of a run are worked out from rep_cfg and the stage delays.
// -----------------------------------------------------------------------------
module tb_lenet_layer_sched;

   localparam int NS = 5;
   localparam int RW = 4;
   localparam int TO = 16;
   localparam int CW = 32;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [NS*RW-1:0] rep_cfg;
   logic [NS-1:0]    stage_en;
   logic [NS-1:0]    stage_finish;
   logic             busy;
   logic             done;
   logic             err;
   logic [2:0]       err_stage;
   logic [2:0]       cur_stage;
   logic [CW-1:0]    total_cycles;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            dly[NS];
   logic [NS-1:0] spur;
   int            en_stage_q[$];
   int            en_cyc_q[$];
   int            done_cnt = 0;

   lenet_layer_sched #(
      .NUM_STAGES (NS),
      .REP_W      (RW),
      .TIMEOUT    (TO),
      .CNT_W      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .rep_cfg      (rep_cfg),
      .stage_en     (stage_en),
      .stage_finish (stage_finish),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .err_stage    (err_stage),
      .cur_stage    (cur_stage),
      .total_cycles (total_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Stage models: finish[s] is high in the cycle dly[s] cycles after the
   // stage_en[s] cycle; dly[s]==0 means the stage never answers.
   initial begin : stage_model
      int            cd[NS];
      logic [NS-1:0] f;
      stage_finish = '0;
      for (int s = 0; s < NS; s++) cd[s] = 0;
      forever begin
         @(negedge clk);
         #1;
         f = spur;
         for (int s = 0; s < NS; s++) begin
            if (cd[s] > 0) begin
               cd[s]--;
               if (cd[s] == 0) f[s] = 1'b1;
            end
         end
         for (int s = 0; s < NS; s++) begin
            if (stage_en[s] && dly[s] > 0) cd[s] = dly[s];
         end
         stage_finish = f;
      end
   end

   // Records every launch (stage, cycle) and counts done pulses.
   initial begin : monitor
      int idx;
      forever begin
         @(negedge clk);
         if (stage_en != '0) begin
            chk("stage_en_onehot", 32'($onehot(stage_en)), 32'd1);
            idx = 0;
            for (int s = 0; s < NS; s++) if (stage_en[s]) idx = s;
            en_stage_q.push_back(idx);
            en_cyc_q.push_back(cyc);
         end
         if (done) done_cnt++;
      end
   end

   // Called at a negedge; starts an inference and checks it end to end.
   task automatic run_inference(input logic [NS*RW-1:0] cfg, input string tag);
      int         exp_s[$];
      int         exp_c[$];
      int         t;
      int         p;
      int         n;
      int         nrep;
      logic [RW-1:0] fld;
      rep_cfg = cfg;
      en_stage_q.delete();
      en_cyc_q.delete();
      done_cnt = 0;
      start = 1'b1;
      p = cyc;
      t = p + 1;
      for (int s = 0; s < NS; s++) begin
         fld  = cfg[s*RW +: RW];
         nrep = (fld == 0) ? 1 : int'(fld);
         for (int r = 0; r < nrep; r++) begin
            exp_s.push_back(s);
            exp_c.push_back(t);
            t = t + dly[s] + 2;
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_at_launch"}, 32'(busy), 32'd1);
      chk({tag, "_err_cleared"}, 32'(err), 32'd0);
      n = 0;
      while (!(done || err) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done), 32'd1);
      chk({tag, "_done_cycle"}, cyc, t);
      chk({tag, "_total_cycles"}, total_cycles, t - (p + 1));
      chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
      chk({tag, "_no_err"}, 32'(err), 32'd0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, "_done_count"}, done_cnt, 32'd1);
      chk({tag, "_launch_count"}, en_stage_q.size(), exp_s.size());
      for (int i = 0; i < exp_s.size() && i < en_stage_q.size(); i++) begin
         chk($sformatf("%s_launch%0d_stage", tag, i), en_stage_q[i], exp_s[i]);
         chk($sformatf("%s_launch%0d_cycle", tag, i), en_cyc_q[i], exp_c[i]);
      end
   endtask

   initial begin : main
      int          n;
      int          t1;
      int          sz;
      logic [31:0] prev_total;
      logic [NS*RW-1:0] cfg;

      rst     = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      rep_cfg = '0;
      spur    = '0;
      for (int s = 0; s < NS; s++) dly[s] = 5;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_stage_en", 32'(stage_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_stage", 32'(err_stage), 32'd0);
      chk("rst_cur_stage", 32'(cur_stage), 32'd0);
      chk("rst_total", total_cycles, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Nominal run: one launch per stage, 5-cycle stages -> 35 cycles
      run_inference(20'h11111, "nominal");
      chk("nominal_total_35", total_cycles, 32'd35);

      // Repeats; stage 2 answers on the last allowed WAIT cycle
      dly[2] = TO - 1;
      run_inference(20'h11310, "repeats");
      dly[2] = 5;

      // Randomised runs
      for (int k = 0; k < 4; k++) begin
         for (int s = 0; s < NS; s++) begin
            cfg[s*RW +: RW] = RW'($urandom_range(0, 3));
            dly[s] = int'($urandom_range(1, TO - 1));
         end
         run_inference(cfg, $sformatf("rand%0d", k));
      end
      for (int s = 0; s < NS; s++) dly[s] = 5;

      // Timeout on stage 1, with a spurious finish and a start while busy
      dly[1] = 0;
      rep_cfg = 20'h11111;
      en_stage_q.delete();
      en_cyc_q.delete();
      done_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (en_stage_q.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("to_stage1_launched", 32'(en_stage_q.size() >= 2), 32'd1);
      t1 = (en_stage_q.size() >= 2) ? en_cyc_q[1] : cyc;
      repeat (2) @(negedge clk);
      spur  = 5'b01000;
      start = 1'b1;
      @(negedge clk);
      spur  = '0;
      start = 1'b0;
      chk("spurious_still_busy", 32'(busy), 32'd1);
      chk("spurious_no_err", 32'(err), 32'd0);
      n = 0;
      while (!err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("to_err", 32'(err), 32'd1);
      chk("to_err_cycle", cyc, t1 + TO);
      chk("to_err_stage", 32'(err_stage), 32'd1);
      chk("to_busy_low", 32'(busy), 32'd0);
      chk("to_cur_stage", 32'(cur_stage), 32'd1);
      chk("to_launches", en_stage_q.size(), 32'd2);
      chk("to_no_done", done_cnt, 32'd0);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", 32'(err), 32'd1);
      chk("to_no_more_launch", en_stage_q.size(), 32'd2);
      dly[1] = 5;
      run_inference(20'h11111, "restart");

      // Abort together with start while waiting on stage 3
      prev_total = total_cycles;
      rep_cfg = 20'h11111;
      en_stage_q.delete();
      en_cyc_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (en_stage_q.size() < 4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ab_stage3_launched", 32'(en_stage_q.size()), 32'd4);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_stage_en", 32'(stage_en), 32'd0);
      chk("ab_cur_stage", 32'(cur_stage), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      chk("ab_err", 32'(err), 32'd0);
      chk("ab_total_kept", total_cycles, prev_total);
      chk("ab_launches", en_stage_q.size(), 32'd4);
      run_inference(20'h11111, "after_abort");

      // Asynchronous reset while waiting on stage 2
      en_stage_q.delete();
      en_cyc_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (en_stage_q.size() < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("mr_waiting_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mr_stage_en", 32'(stage_en), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_cur_stage", 32'(cur_stage), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_total", total_cycles, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      sz = en_stage_q.size();
      repeat (30) @(negedge clk);
      chk("mr_no_launch", en_stage_q.size(), sz);
      chk("mr_idle_busy", 32'(busy), 32'd0);
      run_inference(20'h21112, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
